logic4_rr_arbiter: RTL and testbench
====================================

Name: logic4_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 4-bit logic unit among several requesters. The unit supports AND, OR, XOR and NOT. The block selects one pending request, latches its opcode and operands, and computes the result in a registered stage. It then presents the result with the winner's ID on a valid/ready output port. It sits between the per-lane issue logic and the 4-bit logic datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 4, operand/result width in bits
IDW, 2, width of requester ID; must satisfy 2^IDW >= NREQ

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester request, level; held until own gnt bit seen
op  input  2*NREQ  per-requester opcode, requester i at bits [2i+1:2i]
x  input  W*NREQ  per-requester operand x, requester i at bits [W*i+W-1:W*i]
y  input  W*NREQ  per-requester operand y, same packing as x
gnt  output  NREQ  one-hot grant pulse, one cycle
res_valid  output  1  result available
res_data  output  W  result value
res_id  output  IDW  index of requester that owns res_data
res_ready  input  1  consumer accepts result when high with res_valid

Behaviour:
- One clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - state=IDLE; gnt=0; res_valid=0; res_data=0; res_id=0.
  - Round-robin pointer last_id=NREQ-1, so requester 0 has first priority.
  - Latched op, x and y are 0.
- Opcodes: 00 = x&y; 01 = x|y; 10 = x^y; 11 = ~x (y ignored). All bitwise, width W, no carry.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick winner k: the first set req bit searching last_id+1, last_id+2, ... modulo NREQ.
  - At the clock edge: latch op/x/y of k, set gnt=onehot(k), last_id=k, res_id=k, go to EXEC.
- EXEC (exactly one cycle):
  - gnt is high for this cycle only.
  - Compute the result from the latched values and register it into res_data.
  - Set res_valid=1, go to RESP. gnt returns to 0.
- RESP:
  - res_valid, res_data and res_id are held stable while res_ready==0.
  - On res_valid&&res_ready: res_valid=0 next cycle, go to IDLE.
  - res_data and res_id keep their last values after the handshake.
- Latency: req sampled high in cycle 0 → gnt in cycle 1 → res_valid in cycle 2. Minimum issue interval is 3 cycles.
- The requester drops req (or presents new operands) after seeing its gnt. The latched operands are unaffected by input changes after the IDLE edge.
- A req deasserted before grant is simply not selected; nothing is recorded.
- Simultaneous requests are resolved only by the round-robin pointer. No requester waits more than NREQ grants.
- req changes during EXEC/RESP are ignored until the next IDLE cycle.
- Reset mid-operation (any state): immediate return to reset values. An in-flight result is discarded and never presented.
- No combinational path from req or res_ready to any output; all outputs are registered.

Test Plan:
- Single request: reset, then req=0001, op0=01, x0=0001, y0=0000 → gnt=0001 in cycle 1; res_valid=1, res_data=0001, res_id=0 in cycle 2; res_ready=1 → res_valid=0 in cycle 3.
- All requesters simultaneously, each held until granted, res_ready=1, with ops AND/OR/XOR/NOT, x=1100, y=1010 → grants in order 0,1,2,3, every 3 cycles. Results in order: 1000, 1110, 0110, 0011.
- Backpressure: single OR request, res_ready=0 for 5 cycles after res_valid → res_valid, res_data and res_id stable all 5 cycles. No new gnt even though req1 is pending. On res_ready=1, the next grant goes to req1.
- Fairness: after requester 2 is granted, with req=0101 → next grant goes to requester 0, not 2. Then with req=0100 → grant to 2.
- Reset mid-operation: assert rst_n=0 during EXEC → gnt=0, res_valid=0, res_data=0 immediately, without a clock edge. After release, a req=1000 request is granted to requester 3 through the normal priority order starting at 0.
- Operand isolation: change x0 and y0 in the gnt cycle → res_data reflects the values latched at the IDLE edge. NOT with y=1111 vs y=0000 gives identical results.

Source files
------------

// File: rtl/logic4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// logic4_rr_arbiter
//
// Shares one bitwise logic unit (AND / OR / XOR / NOT) among NREQ requesters.
// A round-robin pointer picks one pending request in IDLE. The winner's opcode
// and operands are latched on that edge and the grant pulses for one cycle
// (EXEC). The result is then registered and offered on a valid/ready port
// tagged with the winner's ID (RESP). Every output comes straight from a flop.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req        in   [NREQ]     level request per requester
//   op         in   [2*NREQ]   opcode per requester (lane i at [2i+1:2i])
//   x, y       in   [W*NREQ]   operands per requester (lane i at [W*i+W-1:W*i])
//   gnt        out  [NREQ]     one-hot grant pulse (one cycle)
//   res_valid  out             result available
//   res_data   out  [W]        result value
//   res_id     out  [IDW]      requester that owns res_data
//   res_ready  in              consumer accepts when high with res_valid
// -----------------------------------------------------------------------------
module logic4_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [2*NREQ-1:0]   op,
  input  logic [W*NREQ-1:0]   x,
  input  logic [W*NREQ-1:0]   y,
  output logic [NREQ-1:0]     gnt,
  output logic                res_valid,
  output logic [W-1:0]        res_data,
  output logic [IDW-1:0]      res_id,
  input  logic                res_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e           state_q;
  logic [IDW-1:0]   last_id_q;
  logic [1:0]       op_q;
  logic [W-1:0]     x_q;
  logic [W-1:0]     y_q;
  logic [NREQ-1:0]  gnt_q;
  logic             res_valid_q;
  logic [W-1:0]     res_data_q;
  logic [IDW-1:0]   res_id_q;

  logic             win_found_s;
  logic [IDW-1:0]   win_id_s;
  logic [IDW-1:0]   cand_s;
  logic [1:0]       op_sel_s;
  logic [W-1:0]     x_sel_s;
  logic [W-1:0]     y_sel_s;

  // Bitwise logic unit; NOT uses x only.
  function automatic logic [W-1:0] logic_op(input logic [1:0] opc,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [W-1:0] r;
    case (opc)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      2'b11:   r = ~a;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Index to one-hot grant vector.
  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] id);
    logic [NREQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

  // Round-robin winner: scan from the farthest candidate down to last_id+1 so
  // the nearest pending requester after the pointer is the last one written.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = '0;
    cand_s      = '0;
    for (int off = NREQ; off >= 1; off--) begin
      cand_s      = IDW'((int'(last_id_q) + off) % NREQ);
      win_found_s = win_found_s | req[cand_s];
      win_id_s    = req[cand_s] ? cand_s : win_id_s;
    end
  end

  // Operand/opcode mux for the current winner.
  always_comb begin
    op_sel_s = '0;
    x_sel_s  = '0;
    y_sel_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_sel_s = (win_id_s == IDW'(i)) ? op[2*i +: 2] : op_sel_s;
      x_sel_s  = (win_id_s == IDW'(i)) ? x[W*i +: W]  : x_sel_s;
      y_sel_s  = (win_id_s == IDW'(i)) ? y[W*i +: W]  : y_sel_s;
    end
  end

  // Control FSM with all datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_id_q   <= IDW'(NREQ - 1);
      op_q        <= 2'b00;
      x_q         <= '0;
      y_q         <= '0;
      gnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_found_s) begin
            op_q      <= op_sel_s;
            x_q       <= x_sel_s;
            y_q       <= y_sel_s;
            gnt_q     <= onehot(win_id_s);
            last_id_q <= win_id_s;
            res_id_q  <= win_id_s;
            state_q   <= S_EXEC;
          end else begin
            gnt_q     <= '0;
          end
        end
        S_EXEC: begin
          res_data_q  <= logic_op(op_q, x_q, y_q);
          res_valid_q <= 1'b1;
          gnt_q       <= '0;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          // res_valid is always high here, so res_ready alone completes it.
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            res_valid_q <= 1'b1;
          end
        end
        default: begin
          gnt_q       <= '0;
          res_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_logic4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// Directed bench for logic4_rr_arbiter. Expected results are pushed to a
// scoreboard queue when a request is issued and popped when the result is
// accepted (res_valid && res_ready).
// -----------------------------------------------------------------------------
module tb_logic4_rr_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req;
  logic [2*NREQ-1:0]   op;
  logic [W*NREQ-1:0]   x;
  logic [W*NREQ-1:0]   y;
  logic [NREQ-1:0]     gnt;
  logic                res_valid;
  logic [W-1:0]        res_data;
  logic [IDW-1:0]      res_id;
  logic                res_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
  } exp_t;

  exp_t sb[$];

  logic [3:0] all_exp [4];

  logic4_rr_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op        (op),
    .x         (x),
    .y         (y),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ready (res_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b);
    case (o)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [1:0] o, input logic [3:0] a, input logic [3:0] b);
    op = (op & ~(8'h3  << (2*i))) | (8'(o)  << (2*i));
    x  = (x  & ~(16'hF << (4*i))) | (16'(a) << (4*i));
    y  = (y  & ~(16'hF << (4*i))) | (16'(b) << (4*i));
  endtask

  task automatic push_lane(input int k);
    exp_t e;
    e.id   = IDW'(k);
    e.data = model(2'(op >> (2*k)), 4'(x >> (4*k)), 4'(y >> (4*k)));
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_data"}, res_data, e.data);
      chk({tag, "_id"},   res_id,   e.id);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_gnt"},   gnt,       32'd0);
    chk({tag, "_valid"}, res_valid, 32'd0);
    chk({tag, "_data"},  res_data,  32'd0);
    chk({tag, "_id"},    res_id,    32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    req   = '0;
    sb.delete();
    #2;
    check_idle_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One full transaction with res_ready high: grant, result, return to idle.
  task automatic run_txn(input logic [3:0] reqv, input int k, input string tag);
    push_lane(k);
    res_ready = 1'b1;
    req       = reqv;
    tick();
    chk({tag, "_gnt"}, gnt, 32'(4'b0001 << k));
    req = reqv & ~(4'b0001 << k);
    tick();
    chk({tag, "_valid"}, res_valid, 32'd1);
    chk({tag, "_gnt_pulse"}, gnt, 32'd0);
    pop_check(tag);
    tick();
    chk({tag, "_valid_drop"}, res_valid, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    op        = '0;
    x         = '0;
    y         = '0;
    res_ready = 1'b0;
    all_exp[0] = 4'b1000;
    all_exp[1] = 4'b1110;
    all_exp[2] = 4'b0110;
    all_exp[3] = 4'b0011;

    // Reset state
    #2;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single OR request from requester 0
    set_lane(0, 2'b01, 4'b0001, 4'b0000);
    run_txn(4'b0001, 0, "single");
    chk("single_const", res_data, 32'h1);

    // All requesters at once, granted 0,1,2,3
    do_reset("reset2");
    for (int i = 0; i < 4; i++) set_lane(i, 2'(i), 4'b1100, 4'b1010);
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      run_txn(req, k, $sformatf("all%0d", k));
      chk($sformatf("all%0d_const", k), res_data, all_exp[k]);
    end

    // Backpressure: result held, pending req1 waits
    set_lane(0, 2'b01, 4'b0011, 4'b0101);
    push_lane(0);
    res_ready = 1'b0;
    req = 4'b0001;
    tick();
    chk("bp_gnt0", gnt, 32'h1);
    set_lane(1, 2'b10, 4'b1111, 4'b0101);
    req = 4'b0010;
    tick();
    chk("bp_valid", res_valid, 32'd1);
    chk("bp_data0", res_data, 32'h7);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp_hold_valid%0d", c), res_valid, 32'd1);
      chk($sformatf("bp_hold_data%0d", c), res_data, 32'h7);
      chk($sformatf("bp_hold_id%0d", c), res_id, 32'd0);
      chk($sformatf("bp_no_gnt%0d", c), gnt, 32'd0);
    end
    res_ready = 1'b1;
    pop_check("bp_accept");
    tick();
    chk("bp_valid_drop", res_valid, 32'd0);
    chk("bp_idle_gnt", gnt, 32'd0);
    push_lane(1);
    tick();
    chk("bp_gnt1", gnt, 32'h2);
    req = 4'b0000;
    tick();
    chk("bp_valid1", res_valid, 32'd1);
    pop_check("bp_req1");
    tick();
    chk("bp_valid1_drop", res_valid, 32'd0);

    // Fairness: after 2, req=0101 goes to 0, then 0100 goes to 2
    set_lane(2, 2'b01, 4'b1001, 4'b0110);
    run_txn(4'b0100, 2, "fair_a");
    run_txn(4'b0101, 0, "fair_b");
    run_txn(4'b0100, 2, "fair_c");
    chk("fair_c_const", res_data, 32'hF);

    // Reset during EXEC discards the in-flight result
    set_lane(1, 2'b00, 4'b1111, 4'b1111);
    push_lane(1);
    req = 4'b0010;
    tick();
    chk("mid_gnt", gnt, 32'h2);
    req = 4'b0000;
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_idle_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("mid_discard%0d", c), res_valid, 32'd0);
    end
    run_txn(4'b1010, 1, "mid_ptr");
    run_txn(4'b1000, 3, "mid_req3");

    // Operand isolation: inputs changed in the grant cycle
    set_lane(0, 2'b11, 4'b0101, 4'b0000);
    push_lane(0);
    req = 4'b0001;
    tick();
    chk("iso_gnt", gnt, 32'h1);
    set_lane(0, 2'b00, 4'b1111, 4'b1111);
    req = 4'b0000;
    tick();
    chk("iso_valid", res_valid, 32'd1);
    chk("iso_const", res_data, 32'hA);
    pop_check("iso");
    tick();
    set_lane(0, 2'b11, 4'b0101, 4'b1111);
    run_txn(4'b0001, 0, "iso_noty");
    chk("iso_noty_const", res_data, 32'hA);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
